// File: rtl/sc_matrix_scan_pkg.sv
// -----------------------------------------------------------------------------
// sc_matrix_scan_pkg
// Shared constants for the LED-matrix scanner: default geometry, default
// row-period length, the ghost-suppression blank length and a width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sc_matrix_scan_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int DEFAULT_ROWS      = 8;
    localparam int DEFAULT_SCANDIV   = 50000;

    // Number of cycles at the start of each row period during which all rows
    // are deselected (only used when SC_MATRIX_SCAN_BLANK_EN is defined).
    localparam int BLANK_LEN         = 4;

    // Counter width that stays legal (>= 1 bit) even for a range of one.
    function automatic int safeClog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sc_matrix_scan_pkg

// File: rtl/sc_matrix_scan_scandiv.sv
// -----------------------------------------------------------------------------
// sc_scandiv
// Row-period prescaler and row index for the matrix scanner.
//   clk        in   system clock, rising edge
//   rstN       in   asynchronous active-low reset
//   tickOut    out  high on the last cycle of every row period
//   idxOut     out  current row index, 0..ROWS-1
//   frameOut   out  high on the last cycle of the last row (frame boundary)
//   blankOut   out  (only with SC_MATRIX_SCAN_BLANK_EN) high for the first
//                   BLANK_LEN cycles of each row period
// -----------------------------------------------------------------------------
module sc_scandiv
    import sc_matrix_scan_pkg::*;
#(
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int SCANDIV = DEFAULT_SCANDIV,
    parameter int IDXW    = safeClog2(ROWS)
) (
    input  logic            clk,
    input  logic            rstN,
`ifdef SC_MATRIX_SCAN_BLANK_EN
    output logic            blankOut,
`endif
    output logic            tickOut,
    output logic [IDXW-1:0] idxOut,
    output logic            frameOut
);

    localparam int DIVW = safeClog2(SCANDIV);

    logic [DIVW-1:0] divCntReg;
    logic [IDXW-1:0] idxReg;
    logic            tickNow;
    logic            lastRow;

    assign tickNow = (divCntReg == DIVW'(SCANDIV - 1));
    assign lastRow = (idxReg == IDXW'(ROWS - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divCntReg <= '0;
            idxReg    <= '0;
        end else if (tickNow) begin
            divCntReg <= '0;
            idxReg    <= lastRow ? '0 : idxReg + IDXW'(1);
        end else begin
            divCntReg <= divCntReg + DIVW'(1);
        end
    end

    assign tickOut  = tickNow;
    assign idxOut   = idxReg;
    assign frameOut = tickNow & lastRow;

`ifdef SC_MATRIX_SCAN_BLANK_EN
    // Compare in integer width so a blank longer than the row period is legal.
    assign blankOut = (int'(divCntReg) < BLANK_LEN);
`endif

endmodule : sc_scandiv

// File: rtl/sc_matrix_scan.sv
// -----------------------------------------------------------------------------
// sc_matrix_scan
// Scrolling LED-matrix row scanner. New row patterns are pushed into a
// one-deep pending register and scrolled into the display buffer at the next
// frame boundary; the buffer is scanned one row per SCANDIV cycles.
//
// Ports:
//   SC_MATRIX_SCAN_CLOCK_50     in   system clock, rising edge
//   SC_MATRIX_SCAN_RESET_InLow  in   asynchronous active-low reset
//   SC_MATRIX_SCAN_data_InBUS   in   new row pattern (DATAWIDTH)
//   SC_MATRIX_SCAN_push_InLow   in   push request, falling edge counts once
//   SC_MATRIX_SCAN_clear_InLow  in   synchronous clear of buffer/pending/overrun
//   SC_MATRIX_SCAN_row_OutBUS   out  active-low one-hot row select (ROWS)
//   SC_MATRIX_SCAN_col_OutBUS   out  column data of the selected row
//   SC_MATRIX_SCAN_frame_Out    out  one-cycle pulse on the frame boundary
//   SC_MATRIX_SCAN_overrun_Out  out  sticky: a pending pattern was overwritten
//
// Build option: define SC_MATRIX_SCAN_BLANK_EN to deselect all rows during
// the first BLANK_LEN cycles of every row period (ghost suppression).
// -----------------------------------------------------------------------------
module sc_matrix_scan
    import sc_matrix_scan_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int ROWS      = DEFAULT_ROWS,
    parameter int SCANDIV   = DEFAULT_SCANDIV
) (
    input  logic                 SC_MATRIX_SCAN_CLOCK_50,
    input  logic                 SC_MATRIX_SCAN_RESET_InLow,
    input  logic [DATAWIDTH-1:0] SC_MATRIX_SCAN_data_InBUS,
    input  logic                 SC_MATRIX_SCAN_push_InLow,
    input  logic                 SC_MATRIX_SCAN_clear_InLow,
    output logic [ROWS-1:0]      SC_MATRIX_SCAN_row_OutBUS,
    output logic [DATAWIDTH-1:0] SC_MATRIX_SCAN_col_OutBUS,
    output logic                 SC_MATRIX_SCAN_frame_Out,
    output logic                 SC_MATRIX_SCAN_overrun_Out
);

    localparam int IDXW = safeClog2(ROWS);

    logic clk;
    logic rstN;
    assign clk  = SC_MATRIX_SCAN_CLOCK_50;
    assign rstN = SC_MATRIX_SCAN_RESET_InLow;

    // ---------------------------------------------------------------- scan timing
    logic            scanTick;
    logic            scanFrame;
    logic [IDXW-1:0] scanIdx;
`ifdef SC_MATRIX_SCAN_BLANK_EN
    logic            scanBlank;
`endif

    sc_scandiv #(
        .ROWS    (ROWS),
        .SCANDIV (SCANDIV),
        .IDXW    (IDXW)
    ) uScanDiv (
        .clk      (clk),
        .rstN     (rstN),
`ifdef SC_MATRIX_SCAN_BLANK_EN
        .blankOut (scanBlank),
`endif
        .tickOut  (scanTick),
        .idxOut   (scanIdx),
        .frameOut (scanFrame)
    );

    // ---------------------------------------------------------------- push path
    logic                 pushPrevReg;
    logic                 pendingReg;
    logic [DATAWIDTH-1:0] pendingDataReg;
    logic                 overrunReg;

    logic pushEvent;
    logic clearNow;
    logic boundary;
    logic scrollNow;

    // The previous-sample register resets to 1 so a push input already low
    // when reset releases still produces one push.
    assign pushEvent = pushPrevReg & ~SC_MATRIX_SCAN_push_InLow;
    assign clearNow  = ~SC_MATRIX_SCAN_clear_InLow;
    assign boundary  = scanTick & scanFrame;
    assign scrollNow = boundary & pendingReg & ~clearNow;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pushPrevReg    <= 1'b1;
            pendingReg     <= 1'b0;
            pendingDataReg <= '0;
            overrunReg     <= 1'b0;
        end else begin
            pushPrevReg <= SC_MATRIX_SCAN_push_InLow;
            if (clearNow) begin
                // Clear beats a simultaneous push: the push is dropped.
                pendingReg <= 1'b0;
                overrunReg <= 1'b0;
            end else if (pushEvent) begin
                // On a boundary the old pending data is consumed by the scroll
                // in this same cycle, so nothing is lost and the new push
                // waits for the next frame.
                pendingDataReg <= SC_MATRIX_SCAN_data_InBUS;
                pendingReg     <= 1'b1;
                if (pendingReg && !boundary) begin
                    overrunReg <= 1'b1;
                end
            end else if (scrollNow) begin
                pendingReg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- display buffer
    // Registers rather than RAM: a scroll moves every row in one cycle.
    logic [DATAWIDTH-1:0] bufferReg [ROWS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : gRow
        logic [DATAWIDTH-1:0] rowSrc;

        if (gi == 0) begin : gHead
            assign rowSrc = pendingDataReg;
        end else begin : gBody
            assign rowSrc = bufferReg[gi-1];
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                bufferReg[gi] <= '0;
            end else if (clearNow) begin
                bufferReg[gi] <= '0;
            end else if (scrollNow) begin
                bufferReg[gi] <= rowSrc;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    logic [ROWS-1:0]      rowSel;
    logic [ROWS-1:0]      rowNext;
    logic [DATAWIDTH-1:0] colNext;

    for (genvar gi = 0; gi < ROWS; gi++) begin : gSel
        assign rowSel[gi] = (scanIdx != IDXW'(gi));
    end

`ifdef SC_MATRIX_SCAN_BLANK_EN
    assign rowNext = scanBlank ? '1 : rowSel;
`else
    assign rowNext = rowSel;
`endif
    assign colNext = bufferReg[scanIdx];

    logic [ROWS-1:0]      rowReg;
    logic [DATAWIDTH-1:0] colReg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rowReg <= '1;
            colReg <= '0;
        end else begin
            rowReg <= rowNext;
            colReg <= colNext;
        end
    end

    assign SC_MATRIX_SCAN_row_OutBUS  = rowReg;
    assign SC_MATRIX_SCAN_col_OutBUS  = colReg;
    assign SC_MATRIX_SCAN_frame_Out   = scanFrame;
    assign SC_MATRIX_SCAN_overrun_Out = overrunReg;

endmodule : sc_matrix_scan

// File: tb/tb_sc_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_sc_matrix_scan
// Bench for sc_matrix_scan with SCANDIV=4, ROWS=8 (32-cycle frame). A
// reference model tracks elapsed cycles, the buffer as an array and the
// pending/overrun state, and predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_sc_matrix_scan;

    localparam int DW    = 8;
    localparam int NROWS = 8;
    localparam int DIV   = 4;
    localparam int FRAME = NROWS * DIV;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          pushIn = 1'b1;
    logic          clearIn = 1'b1;
    logic [NROWS-1:0] rowOut;
    logic [DW-1:0] colOut;
    logic          frameOut;
    logic          overrunOut;

    always #5 clk = ~clk;

    sc_matrix_scan #(
        .DATAWIDTH (DW),
        .ROWS      (NROWS),
        .SCANDIV   (DIV)
    ) dut (
        .SC_MATRIX_SCAN_CLOCK_50    (clk),
        .SC_MATRIX_SCAN_RESET_InLow (rstN),
        .SC_MATRIX_SCAN_data_InBUS  (dataIn),
        .SC_MATRIX_SCAN_push_InLow  (pushIn),
        .SC_MATRIX_SCAN_clear_InLow (clearIn),
        .SC_MATRIX_SCAN_row_OutBUS  (rowOut),
        .SC_MATRIX_SCAN_col_OutBUS  (colOut),
        .SC_MATRIX_SCAN_frame_Out   (frameOut),
        .SC_MATRIX_SCAN_overrun_Out (overrunOut)
    );

    // ---------------------------------------------------------------- model
    logic [DW-1:0] mBuf [NROWS];
    bit            mPend;
    logic [DW-1:0] mPendData;
    bit            mOver;
    bit            mPrevPush;
    int            n;          // rising edges since reset release

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NROWS; i++) mBuf[i] = '0;
        mPend     = 0;
        mPendData = '0;
        mOver     = 0;
        mPrevPush = 1;
        n         = 0;
    endtask

    // Advance one clock: predict from the pre-edge state and current inputs,
    // then compare DUT outputs 1 time unit after the edge.
    task automatic stepCycle();
        int            idx;
        bit            boundary;
        bit            pushEv;
        logic [NROWS-1:0] eRow;
        logic [DW-1:0] eCol;

        idx      = (n / DIV) % NROWS;
        eRow     = ~(NROWS'(1) << idx);
        eCol     = mBuf[idx];
        boundary = ((n % FRAME) == FRAME - 1);
        pushEv   = mPrevPush && !pushIn;

        if (!clearIn) begin
            for (int i = 0; i < NROWS; i++) mBuf[i] = '0;
            mPend = 0;
            mOver = 0;
        end else begin
            if (boundary && mPend) begin
                for (int i = NROWS - 1; i > 0; i--) mBuf[i] = mBuf[i-1];
                mBuf[0] = mPendData;
                mPend   = 0;
            end
            if (pushEv) begin
                if (mPend) mOver = 1;
                mPendData = dataIn;
                mPend     = 1;
            end
        end
        mPrevPush = pushIn;
        n++;

        @(posedge clk);
        #1;
        check("row", 32'(rowOut), 32'(eRow));
        check("col", 32'(colOut), 32'(eCol));
        check("frame", 32'(frameOut), 32'(((n % FRAME) == FRAME - 1)));
        check("overrun", 32'(overrunOut), 32'(mOver));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    task automatic pushByte(input logic [DW-1:0] d);
        dataIn = d;
        pushIn = 1'b0;
        stepCycle();
        pushIn = 1'b1;
        dataIn = DW'($urandom);
        stepCycle();
    endtask

    // Assert reset, optionally check outputs before any clock edge, hold for
    // two cycles, check again, release on a falling edge.
    task automatic doReset(input bit immediate);
        rstN = 1'b0;
        #1;
        if (immediate) begin
            check("rst_row_now", 32'(rowOut), 32'(8'hFF));
            check("rst_col_now", 32'(colOut), 32'(8'h00));
            check("rst_ovr_now", 32'(overrunOut), 32'(1'b0));
        end
        repeat (2) @(negedge clk);
        check("rst_row", 32'(rowOut), 32'(8'hFF));
        check("rst_col", 32'(colOut), 32'(8'h00));
        check("rst_frame", 32'(frameOut), 32'(1'b0));
        check("rst_overrun", 32'(overrunOut), 32'(1'b0));
        rstN = 1'b1;
        modelReset();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        modelReset();
        doReset(1'b0);

        // Single push, shown at row 0 after the next boundary.
        pushByte(8'h81);
        run(FRAME + 8);

        // One push per frame: oldest pattern moves down.
        pushByte(8'h01);
        run(FRAME);
        pushByte(8'h02);
        run(FRAME);
        pushByte(8'h04);
        run(FRAME + 8);

        // Two pushes in the same frame: latest wins, overrun raised.
        run((FRAME - (n % FRAME)) + 2);
        pushByte(8'h11);
        pushByte(8'h22);
        run(FRAME + 4);
        clearIn = 1'b0;
        stepCycle();
        clearIn = 1'b1;
        run(8);

        // Clear and push falling edge in the same cycle; push held low after.
        pushByte(8'h5A);
        run(FRAME);
        dataIn  = 8'h3C;
        clearIn = 1'b0;
        pushIn  = 1'b0;
        stepCycle();
        clearIn = 1'b1;
        run(5);
        pushIn = 1'b1;
        run(FRAME + 4);

        // Push landing exactly on a frame boundary cycle.
        pushByte(8'hA5);
        run((FRAME - 1) - (n % FRAME));
        pushByte(8'h77);
        run(2 * FRAME);

        // Randomized traffic: push toggles, held-low pushes, occasional clears.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 5) == 0) pushIn = ~pushIn;
            dataIn  = DW'($urandom);
            clearIn = ($urandom_range(0, 79) != 0);
            stepCycle();
        end
        clearIn = 1'b1;
        pushIn  = 1'b1;
        run(FRAME);

        // Reset mid-frame with a push pending: scanning restarts at row 0.
        pushByte(8'hC3);
        run(5);
        doReset(1'b1);
        run(2 * FRAME + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sc_matrix_scan
